fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Shares the write port of one Fifo instance among NREQ producers, using round-robin burst grants. Each grant allows up to BURST words. Flow control comes from the Fifo's available count, so the Fifo is never overrun. Sits directly in front of the Fifo's wr_en/wr_dat and replaces ad-hoc per-producer muxing.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 32, data word width; must match the Fifo's WIDTH
DEPTH, 16, depth of the attached Fifo (power of two); must match the Fifo's DEPTH
BURST, 4, maximum words written per grant (1..DEPTH)

Ports:
clk  input  1  clock
rst_b  input  1  asynchronous active-low reset
req  input  NREQ  per-requester "data valid"; req[i] held high while requester i has a word on its slice of req_dat
req_dat  input  NREQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]
ack  output  NREQ  ack[i]=1: word from requester i written this cycle; requester advances its data next cycle
gnt  output  NREQ  one-hot current grant, registered; all zero when idle
fifo_available  input  clog2(DEPTH)+1  occupancy from the Fifo's available output
fifo_wr_en  output  1  to the Fifo's wr_en
fifo_wr_dat  output  WIDTH  to the Fifo's wr_dat
busy  output  1  high while in state BURST

Behaviour:
- Reset is asynchronous and active-low; clock is clk.
- Reset values: state=IDLE, gnt=0, prio pointer=0, burst count=0, busy=0. fifo_wr_en and ack are 0 because they are combinational from state.
- space = (fifo_available != DEPTH). fifo_available already reflects every write issued up to the previous edge, so no extra pending-write correction is needed.
- IDLE state:
  - If any req is high and space=1, pick the first set req[i] scanning from prio upward with wrap-around.
  - Next edge: gnt<=one-hot(i), cnt<=0, state<=BURST.
  - No writes are issued in IDLE (one-cycle arbitration bubble per grant).
- BURST state, write condition:
  - fifo_wr_en = req[g] && space, where g is the granted index.
  - ack = gnt & {NREQ{fifo_wr_en}}.
  - fifo_wr_dat = req_dat slice g (combinational mux, zero added latency).
  - Each write increments cnt.
- BURST exit: return to IDLE at the next edge when any of these holds:
  - a write occurs with cnt==BURST-1;
  - req[g]==0;
  - space==0.
- On exit: gnt<=0, prio<=(g+1) mod NREQ. prio rotates even if zero words were written, so a starving holder cannot lock out others.
- Full boundary: when the Fifo goes full mid-burst, the write that filled it is the last one. The next cycle sees space=0 and exits. fifo_wr_en is never asserted with fifo_available==DEPTH.
- A requester dropping req mid-burst is legal; the burst terminates without a write that cycle.
- Requests that change while a grant is held do not preempt the current grant.
- Reset mid-burst: gnt and fifo_wr_en drop immediately (asynchronous). Any partially written burst stays in the Fifo.
- Latency: first write occurs 1 cycle after req rises (IDLE->BURST edge), then 1 word/cycle. Max sustained throughput is BURST/(BURST+1).

Optional Feature:
FIFO_ARB_STALL_CNT_EN
- Defined:
  - Adds output stall_cnt [15:0], reset 0.
  - Increments (saturating at 16'hFFFF) each cycle in IDLE where any req is high and space==0.
  - Also increments each BURST cycle where req[g]==1 and space==0.
  - Adds input stall_clr (synchronous clear; clear wins over increment).
- Not defined: neither port exists; no counter logic.

Test Plan:
- Only req[1]=1 with 10 words, Fifo empty, BURST=4 -> writes 4,4,2 with one idle cycle between bursts; gnt=0010 during each burst; ack[1] pulses 10 times; data order preserved.
- req=1111 held, Fifo drained every cycle -> grant order 0,1,2,3,0; each holds 4 writes; prio ends at 1 after requester 0's second burst.
- Fifo at available=14 (DEPTH=16), req[2]=1 -> exactly 2 writes, burst exits, no fifo_wr_en while available==16; after 1 read, 1 more write following a new grant.
- req[3] drops after 2 words of a burst -> burst ends that cycle, prio=0, next grant goes to req[0] if asserted.
- rst_b asserted mid-burst with gnt=0100 -> gnt=0, fifo_wr_en=0, busy=0 immediately; after release, arbitration restarts from prio=0.
- With FIFO_ARB_STALL_CNT_EN: Fifo full, req[0]=1 for 5 cycles -> stall_cnt=5; stall_clr pulse -> 0 next cycle.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one Fifo write port among NREQ producers.
// Optional stall counter enabled by defining FIFO_ARB_STALL_CNT_EN.
module fifo_wr_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst_b,
  input  logic [NREQ-1:0]           req_i,
  input  logic [NREQ*WIDTH-1:0]     req_dat_i,
  output logic [NREQ-1:0]           ack_o,
  output logic [NREQ-1:0]           gnt_o,
  input  logic [$clog2(DEPTH):0]    fifo_available_i,
  output logic                      fifo_wr_en_o,
  output logic [WIDTH-1:0]          fifo_wr_dat_o,
`ifdef FIFO_ARB_STALL_CNT_EN
  input  logic                      stall_clr_i,
  output logic [15:0]               stall_cnt_o,
`endif
  output logic                      busy_o
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CntW = $clog2(BURST) + 1;
  localparam int unsigned AvW  = $clog2(DEPTH) + 1;
  localparam logic [AvW-1:0]  Full    = AvW'(DEPTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(BURST - 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NREQ - 1);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StBurst = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0] prio_q, prio_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] g_idx, pick_idx;
  logic            pick_vld, space, req_g, wr_en, burst_end;

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) g_idx = IdxW'(i);
    end
  end

  // Descending offset scan: the last hit is the first requester at or above prio.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_i[i] && (i == (int'(prio_q) + k) % int'(NREQ))) begin
          pick_vld = 1'b1;
          pick_idx = IdxW'(i);
        end
      end
    end
  end

  assign space         = (fifo_available_i != Full);
  assign req_g         = |(req_i & gnt_q);
  assign wr_en         = (state_q == StBurst) && req_g && space;
  assign burst_end     = (wr_en && (cnt_q == LastCnt)) || !req_g || !space;
  assign fifo_wr_en_o  = wr_en;
  assign ack_o         = gnt_q & {NREQ{wr_en}};
  assign fifo_wr_dat_o = req_dat_i[g_idx*WIDTH +: WIDTH];
  assign gnt_o         = gnt_q;
  assign busy_o        = (state_q == StBurst);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (pick_vld && space) begin
          gnt_d   = NREQ'(1) << pick_idx;
          cnt_d   = '0;
          state_d = StBurst;
        end
      end
      StBurst: begin
        if (wr_en) cnt_d = cnt_q + CntW'(1);
        // Rotate even after an empty burst so a stalled holder cannot starve others.
        if (burst_end) begin
          state_d = StIdle;
          gnt_d   = '0;
          prio_d  = (g_idx == LastIdx) ? '0 : g_idx + IdxW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      prio_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FIFO_ARB_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;
  logic        stall_inc;

  assign stall_inc = !space && (((state_q == StIdle) && |req_i) ||
                                ((state_q == StBurst) && req_g));

  always_comb begin
    stall_d = stall_q;
    if (stall_clr_i)                           stall_d = '0;
    else if (stall_inc && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a behavioural Fifo occupancy model.
// Stall counter checks compile in when FIFO_ARB_STALL_CNT_EN is defined.
module tb_fifo_wr_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int BURST = 4;

  logic         clk = 1'b0;
  logic         rst_b;
  logic [3:0]   req;
  logic [127:0] req_dat;
  logic [3:0]   ack, gnt;
  logic [4:0]   fifo_available;
  logic         fifo_wr_en;
  logic [31:0]  fifo_wr_dat;
  logic         busy;
`ifdef FIFO_ARB_STALL_CNT_EN
  logic         stall_clr;
  logic [15:0]  stall_cnt;
`endif

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NREQ (NREQ),
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .BURST(BURST)
  ) dut (
    .clk             (clk),
    .rst_b           (rst_b),
    .req_i           (req),
    .req_dat_i       (req_dat),
    .ack_o           (ack),
    .gnt_o           (gnt),
    .fifo_available_i(fifo_available),
    .fifo_wr_en_o    (fifo_wr_en),
    .fifo_wr_dat_o   (fifo_wr_dat),
`ifdef FIFO_ARB_STALL_CNT_EN
    .stall_clr_i     (stall_clr),
    .stall_cnt_o     (stall_cnt),
`endif
    .busy_o          (busy)
  );

  int         vectors = 0;
  int         errs    = 0;
  logic [3:0] mask;
  int         rem [4];
  int         ptr [4];
  int         avail;

  // Per-cycle expectations, left to right = cycle 0 onward.
  bit   [0:14]  t1_wr = 15'b011110111101100;
  logic [3:0]   t1_g [15] = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h2, 4'h2,
                              4'h2, 4'h2, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0};
  bit   [0:10]  t3_wr = 11'b01100000100;
  logic [3:0]   t3_g [11] = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0,
                              4'h4, 4'h4, 4'h0};
  bit   [0:5]   t4_wr = 6'b011001;
  logic [3:0]   t4_g [6] = '{4'h0, 4'h8, 4'h8, 4'h8, 4'h0, 4'h1};

  function automatic logic [31:0] word(input int i, input int n);
    return 32'hA000_0000 | (32'(i) << 16) | 32'(n);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req[i]             = mask[i] && (rem[i] > 0);
      req_dat[i*32 +: 32] = word(i, ptr[i]);
    end
    fifo_available = 5'(avail);
  endtask

  // Called at a falling edge with inputs settled; checks, clocks, updates the Fifo model.
  task automatic step(input string tag, input bit rd, input bit exp_wr, input logic [3:0] exp_gnt);
    logic       obs_wr;
    logic [3:0] obs_ack;
    int         gi;
    #1;
    chk({tag, ".gnt"},  32'(gnt),        32'(exp_gnt));
    chk({tag, ".wr"},   32'(fifo_wr_en), 32'(exp_wr));
    chk({tag, ".ack"},  32'(ack),        32'(exp_wr ? exp_gnt : 4'h0));
    chk({tag, ".busy"}, 32'(busy),       32'(exp_gnt != 4'h0));
    if (exp_wr) begin
      gi = 0;
      for (int i = 0; i < 4; i++) if (exp_gnt[i]) gi = i;
      chk({tag, ".dat"}, fifo_wr_dat, word(gi, ptr[gi]));
    end
    obs_wr  = fifo_wr_en;
    obs_ack = ack;
    @(posedge clk);
    #1;
    if (obs_wr) avail++;
    if (rd && avail > 0) avail--;
    for (int i = 0; i < 4; i++) begin
      if (obs_ack[i]) begin
        ptr[i]++;
        rem[i]--;
      end
    end
    drive();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    mask  = '0;
    avail = 0;
    for (int i = 0; i < 4; i++) begin
      rem[i] = 0;
      ptr[i] = 0;
    end
`ifdef FIFO_ARB_STALL_CNT_EN
    stall_clr = 1'b0;
`endif
    drive();
    #1;
    chk("rst.gnt",  32'(gnt),        32'h0);
    chk("rst.wr",   32'(fifo_wr_en), 32'h0);
    chk("rst.ack",  32'(ack),        32'h0);
    chk("rst.busy", 32'(busy),       32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_b = 1'b1;
    mask  = '0;
    avail = 0;
    for (int i = 0; i < 4; i++) begin
      rem[i] = 0;
      ptr[i] = 0;
    end
`ifdef FIFO_ARB_STALL_CNT_EN
    stall_clr = 1'b0;
`endif
    drive();
    #2;

    // Single requester, 10 words: bursts of 4,4,2 separated by one idle cycle.
    do_reset();
    mask   = 4'b0010;
    rem[1] = 10;
    drive();
    for (int k = 0; k < 15; k++) step("t1", 1'b0, t1_wr[k], t1_g[k]);
    chk("t1.words", 32'(ptr[1]), 32'd10);
    chk("t1.avail", 32'(avail),  32'd10);

    // All four requesting, Fifo drained: order 0,1,2,3,0 then 1.
    do_reset();
    mask = 4'b1111;
    for (int i = 0; i < 4; i++) rem[i] = 100;
    drive();
    for (int k = 0; k < 27; k++)
      step("t2", 1'b1, (k % 5) != 0, (k % 5 == 0) ? 4'h0 : 4'(1 << ((k / 5) % 4)));
    chk("t2.words0", 32'(ptr[0]), 32'd8);
    chk("t2.words3", 32'(ptr[3]), 32'd4);

    // Near-full Fifo: two writes fill it, then one more after a single read.
    do_reset();
    avail  = 14;
    mask   = 4'b0100;
    rem[2] = 10;
    drive();
    for (int k = 0; k < 11; k++) step("t3", k == 6, t3_wr[k], t3_g[k]);
    chk("t3.words", 32'(ptr[2]), 32'd3);
    chk("t3.avail", 32'(avail),  32'd16);

    // Requester 3 drops after 2 words; req[0] raised mid-burst must not preempt.
    do_reset();
    mask   = 4'b1000;
    rem[3] = 2;
    drive();
    for (int k = 0; k < 6; k++) begin
      if (k == 1) begin
        mask[0] = 1'b1;
        rem[0]  = 5;
        drive();
      end
      step("t4", 1'b0, t4_wr[k], t4_g[k]);
    end

    // Reset during requester 2's burst; arbitration restarts from priority 0.
    do_reset();
    mask   = 4'b0110;
    rem[1] = 1;
    rem[2] = 50;
    drive();
    step("t5a", 1'b0, 1'b0, 4'h0);
    step("t5a", 1'b0, 1'b1, 4'h2);
    step("t5a", 1'b0, 1'b0, 4'h2);
    step("t5a", 1'b0, 1'b0, 4'h0);
    step("t5a", 1'b0, 1'b1, 4'h4);
    rst_b = 1'b0;
    #1;
    chk("t5.rst_gnt",  32'(gnt),        32'h0);
    chk("t5.rst_wr",   32'(fifo_wr_en), 32'h0);
    chk("t5.rst_busy", 32'(busy),       32'h0);
    chk("t5.rst_ack",  32'(ack),        32'h0);
    @(negedge clk);
    rst_b = 1'b1;
    mask  = 4'b1111;
    for (int i = 0; i < 4; i++) rem[i] = 50;
    drive();
    step("t5b", 1'b0, 1'b0, 4'h0);
    step("t5b", 1'b0, 1'b1, 4'h1);

`ifdef FIFO_ARB_STALL_CNT_EN
    // Full Fifo with req[0] for 5 cycles, then a clear pulse.
    do_reset();
    avail  = 16;
    mask   = 4'b0001;
    rem[0] = 5;
    drive();
    for (int k = 0; k < 5; k++) step("t6", 1'b0, 1'b0, 4'h0);
    chk("t6.stall5", 32'(stall_cnt), 32'd5);
    stall_clr = 1'b1;
    step("t6", 1'b0, 1'b0, 4'h0);
    stall_clr = 1'b0;
    chk("t6.stallclr", 32'(stall_cnt), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
